// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the pipeline MEM stage and the camera
// pixel writer. CPU accesses win by default. Camera words are buffered in a
// small FIFO and written into a wrapping frame buffer. A starvation counter
// forces a camera grant, stalling the pipeline for that one cycle.
module dmem_port_arbiter #(
  parameter logic [31:0] FB_BASE      = 32'h0000_1000,
  parameter int          FB_WORDS     = 4800,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          MAX_CAM_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall_m,
  input  logic        cam_valid,
  input  logic [31:0] cam_data,
  output logic        cam_ready,
  input  logic        cam_frame_start,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        frame_done,
  output logic        cam_overflow
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OFF_W  = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
  localparam int WAIT_W = $clog2(MAX_CAM_WAIT + 1);

  // Small FIFO storage; the head is read combinationally so a camera grant
  // can drive its data onto the port in the same cycle.
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [OFF_W-1:0]  wr_off_reg;
  logic [WAIT_W-1:0] wait_reg;
  logic              frame_done_reg;
  logic              overflow_reg;

  logic cpu_req;
  logic cam_req;
  logic force_cam;
  logic gnt_cam;
  logic gnt_cpu;
  logic push;
  logic pop;
  logic last_word;

  // Request decode and grant selection for the current cycle.
  always_comb begin
    cpu_req   = cpu_we | cpu_re;
    cam_req   = (count_reg != '0) & ~cam_frame_start;
    force_cam = cam_req & (wait_reg == WAIT_W'(MAX_CAM_WAIT));
    gnt_cam   = force_cam | (cam_req & ~cpu_req);
    gnt_cpu   = cpu_req & ~force_cam;
    cam_ready = (count_reg != CNT_W'(FIFO_DEPTH)) & ~reset;
    push      = cam_valid & cam_ready;
    pop       = gnt_cam & ~reset;
    last_word = (wr_off_reg == OFF_W'(FB_WORDS - 1));
  end

  // Memory port mux; everything is quiet while reset is asserted so an
  // in-flight camera write is dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    cpu_rdata = 32'h0;
    stall_m   = 1'b0;
    if (!reset) begin
      if (gnt_cam) begin
        mem_we    = 1'b1;
        mem_addr  = FB_BASE + (32'(wr_off_reg) << 2);
        mem_wdata = fifo_mem[rd_ptr_reg];
        stall_m   = cpu_req;
      end else if (gnt_cpu) begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
      end
    end
  end

  // FIFO data write; a push during a frame-start pulse lands in slot 0 so it
  // becomes the sole entry of the freshly cleared FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[cam_frame_start ? PTR_W'(0) : wr_ptr_reg] <= cam_data;
    end
  end

  // FIFO bookkeeping, frame offset, starvation counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      wr_off_reg     <= '0;
      wait_reg       <= '0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else if (cam_frame_start) begin
      // Discard the old frame; keep only a word arriving with the pulse.
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= push ? PTR_W'(1) : PTR_W'(0);
      count_reg      <= push ? CNT_W'(1) : CNT_W'(0);
      wr_off_reg     <= '0;
      wait_reg       <= '0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end

      if (pop) begin
        wr_off_reg <= last_word ? OFF_W'(0) : wr_off_reg + OFF_W'(1);
      end
      frame_done_reg <= pop & last_word;

      // Counts cycles a buffered word has been passed over.
      if (gnt_cam || count_reg == '0) begin
        wait_reg <= '0;
      end else if (wait_reg != WAIT_W'(MAX_CAM_WAIT)) begin
        wait_reg <= wait_reg + WAIT_W'(1);
      end

      if (cam_valid && !cam_ready) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign frame_done   = frame_done_reg;
  assign cam_overflow = overflow_reg;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed steps from the test
// plan followed by randomized traffic, compared every cycle against a
// queue-based reference model of the arbiter.
module tb_dmem_port_arbiter;

  localparam logic [31:0] FB_BASE = 32'h0000_1000;
  localparam int FBW   = 4;
  localparam int DEPTH = 4;
  localparam int MAXW  = 8;

  logic        clk;
  logic        reset;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall_m;
  logic        cam_valid;
  logic [31:0] cam_data;
  logic        cam_ready;
  logic        cam_frame_start;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        frame_done;
  logic        cam_overflow;

  dmem_port_arbiter #(
    .FB_BASE(FB_BASE), .FB_WORDS(FBW), .FIFO_DEPTH(DEPTH), .MAX_CAM_WAIT(MAXW)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stall_m(stall_m),
    .cam_valid(cam_valid), .cam_data(cam_data), .cam_ready(cam_ready),
    .cam_frame_start(cam_frame_start),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .frame_done(frame_done), .cam_overflow(cam_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment data memory (combinational read), written from the main block.
  logic [31:0] ram [2048];
  assign mem_rdata = ram[mem_addr[12:2]];

  // Reference model state.
  logic [31:0] q[$];
  int          off;
  int          waitc;
  bit          fd;
  bit          ovf;
  logic [31:0] ref_ram [2048];

  // Expected values for the current cycle.
  bit          x_gc;
  bit          x_ready;
  logic        x_we;
  logic        x_stall;
  logic [31:0] x_addr;
  logic [31:0] x_wdata;
  logic [31:0] x_rdata;

  // Pending environment write captured from the DUT outputs.
  logic        p_we;
  logic [31:0] p_addr;
  logic [31:0] p_data;

  int n_assert;
  int n_fail;
  int cyc;
  int fd_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compute expectations from the model and compare at the falling edge.
  task automatic eval();
    bit cpu_req, cam_req, frc, gcpu;
    @(negedge clk);
    if (reset) begin
      x_gc = 0; x_ready = 0; x_we = 0; x_stall = 0; x_rdata = 32'h0;
      x_addr = 32'h0; x_wdata = 32'h0;
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_stall", stall_m, 1'b0);
      chk("rst_ready", cam_ready, 1'b0);
      chk("rst_rdata", cpu_rdata, 32'h0);
    end else begin
      cpu_req = cpu_we || cpu_re;
      cam_req = (q.size() != 0) && !cam_frame_start;
      frc     = cam_req && (waitc == MAXW);
      x_gc    = frc || (cam_req && !cpu_req);
      gcpu    = cpu_req && !frc;
      x_ready = (q.size() != DEPTH);
      x_we = 0; x_addr = 0; x_wdata = 0; x_rdata = 0; x_stall = 0;
      if (x_gc) begin
        x_we = 1; x_addr = FB_BASE + 32'(off * 4); x_wdata = q[0]; x_stall = cpu_req;
      end else if (gcpu) begin
        x_we = cpu_we; x_addr = cpu_addr; x_wdata = cpu_wdata;
        x_rdata = ref_ram[cpu_addr[12:2]];
      end
      chk("mem_we", mem_we, x_we);
      chk("mem_addr", mem_addr, x_addr);
      chk("mem_wdata", mem_wdata, x_wdata);
      chk("cpu_rdata", cpu_rdata, x_rdata);
      chk("stall_m", stall_m, x_stall);
      chk("cam_ready", cam_ready, x_ready);
    end
    chk("frame_done", frame_done, fd);
    chk("cam_overflow", cam_overflow, ovf);
    p_we = mem_we; p_addr = mem_addr; p_data = mem_wdata;
    $display("cyc %0d rst=%b we=%b re=%b a=%h cv=%b fs=%b | mem_we=%b mem_addr=%h wd=%h stall=%b rdy=%b fd=%b ovf=%b",
             cyc, reset, cpu_we, cpu_re, cpu_addr, cam_valid, cam_frame_start,
             mem_we, mem_addr, mem_wdata, stall_m, cam_ready, frame_done, cam_overflow);
  endtask

  // Clock edge: advance the reference model and the environment memory.
  task automatic adv();
    int sz;
    @(posedge clk);
    if (p_we) ram[p_addr[12:2]] = p_data;
    if (reset) begin
      q.delete(); off = 0; waitc = 0; fd = 0; ovf = 0;
    end else begin
      if (x_we) ref_ram[x_addr[12:2]] = x_wdata;
      if (cam_frame_start) begin
        q.delete();
        if (cam_valid && x_ready) q.push_back(cam_data);
        off = 0; waitc = 0; ovf = 0; fd = 0;
      end else begin
        sz = q.size();
        if (x_gc) begin
          void'(q.pop_front());
          fd  = (off == FBW - 1);
          off = (off + 1) % FBW;
        end else begin
          fd = 0;
        end
        if (cam_valid && x_ready) q.push_back(cam_data);
        if (x_gc || sz == 0) waitc = 0;
        else if (waitc < MAXW) waitc++;
        if (cam_valid && !x_ready) ovf = 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  task automatic frame_pulse();
    cam_frame_start = 1; step(); cam_frame_start = 0;
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0; fd_seen = 0;
    for (int i = 0; i < 2048; i++) begin ram[i] = 32'h0; ref_ram[i] = 32'h0; end
    off = 0; waitc = 0; fd = 0; ovf = 0;
    reset = 1; cpu_we = 0; cpu_re = 0; cpu_addr = 0; cpu_wdata = 0;
    cam_valid = 0; cam_data = 0; cam_frame_start = 0;

    // Reset, then idle.
    step(); step();
    reset = 0;
    eval();
    chk("idle_ready", cam_ready, 1'b1);
    chk("idle_we", mem_we, 1'b0);
    chk("idle_stall", stall_m, 1'b0);
    adv();

    // CPU store then load.
    cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF;
    eval();
    chk("st_we", mem_we, 1'b1);
    chk("st_addr", mem_addr, 32'h40);
    chk("st_data", mem_wdata, 32'hDEADBEEF);
    adv();
    cpu_we = 0; cpu_re = 1;
    eval();
    chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
    adv();
    cpu_re = 0;

    // Single pixel with CPU idle.
    cam_valid = 1; cam_data = 32'h00AA55FF; step(); cam_valid = 0;
    eval();
    chk("px_we", mem_we, 1'b1);
    chk("px_addr", mem_addr, 32'h1000);
    chk("px_data", mem_wdata, 32'h00AA55FF);
    adv();
    step();

    // Starvation: continuous CPU loads with one pixel queued.
    frame_pulse();
    cpu_re = 1; cpu_addr = 32'h40;
    cam_valid = 1; cam_data = 32'h11112222; step(); cam_valid = 0;
    for (int i = 0; i < 8; i++) begin
      eval();
      chk("starve_wait_stall", stall_m, 1'b0);
      chk("starve_wait_addr", mem_addr, 32'h40);
      adv();
    end
    eval();
    chk("force_stall", stall_m, 1'b1);
    chk("force_addr", mem_addr, 32'h1000);
    chk("force_data", mem_wdata, 32'h11112222);
    adv();
    eval();
    chk("after_force_stall", stall_m, 1'b0);
    chk("after_force_rdata", cpu_rdata, 32'hDEADBEEF);
    adv();

    // Overflow with CPU busy, then frame start recovers.
    frame_pulse();
    for (int i = 0; i < 6; i++) begin
      cam_valid = 1; cam_data = 32'hC0 + 32'(i);
      eval();
      if (i == 4) chk("ovf_ready_low", cam_ready, 1'b0);
      adv();
    end
    cam_valid = 0;
    eval();
    chk("ovf_set", cam_overflow, 1'b1);
    adv();
    cpu_re = 0;
    frame_pulse();
    eval();
    chk("ovf_cleared", cam_overflow, 1'b0);
    chk("fifo_cleared_ready", cam_ready, 1'b1);
    chk("fifo_cleared_we", mem_we, 1'b0);
    adv();
    cam_valid = 1; cam_data = 32'h0BADF00D; step(); cam_valid = 0;
    eval();
    chk("post_fs_addr", mem_addr, 32'h1000);
    chk("post_fs_data", mem_wdata, 32'h0BADF00D);
    adv();

    // Frame wrap with FB_WORDS=4: five pixels streamed, CPU idle.
    frame_pulse();
    for (int i = 0; i < 7; i++) begin
      cam_valid = (i < 5); cam_data = 32'hF000 + 32'(i);
      eval();
      if (frame_done) fd_seen++;
      if (i >= 1 && i <= 5) chk("wrap_addr", mem_addr, 32'h1000 + 32'(((i - 1) % 4) * 4));
      chk("wrap_fd", frame_done, (i == 5) ? 1'b1 : 1'b0);
      adv();
    end
    cam_valid = 0;
    chk("wrap_fd_pulses", 32'(fd_seen), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!x_stall) begin
        cpu_we = ($urandom_range(0, 3) == 0);
        cpu_re = !cpu_we && ($urandom_range(0, 2) == 0);
        cpu_addr = 32'($urandom_range(0, 511)) << 2;
        cpu_wdata = $urandom;
      end
      cam_valid = ($urandom_range(0, 2) != 0);
      cam_data = $urandom;
      cam_frame_start = ($urandom_range(0, 39) == 0);
      step();
    end
    reset = 0; cpu_we = 0; cpu_re = 0; cam_valid = 0; cam_frame_start = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
